rc4_key_search_ctrl: RTL and testbench
======================================

// Module: rc4_key_search_ctrl
// PURPOSE
//  Top-level scheduler for the RC4 breaker: iterates candidate keys and sequences the three phase engines
//  (S init, key-schedule shuffle, decrypt) over one shared S memory via start/done handshakes.
//  Owns the S-memory port select, scans the decrypted message for a valid plaintext and reports found key or exhaustion.
// PARAMETERS
//  KEY_WIDTH  24         candidate key width
//  KEY_MIN    24'h000000 first key tried
//  KEY_MAX    24'h3FFFFF last key tried (inclusive)
//  MSG_DEP    32         decrypted message length, bytes
//  MSG_WIDTH  8          message byte width
// PORTS
//  clk        in   1                   clock
//  reset      in   1                   synchronous, active-high
//  start      in   1                   begin search (sampled in IDLE only)
//  init_done  in   1                   S init engine finished (level)
//  ksa_done   in   1                   shuffle engine finished (level)
//  dec_done   in   1                   decrypt engine finished (level)
//  decrypted  in   MSG_WIDTH x MSG_DEP decrypt engine output array
//  eng_clear  out  1                   one-cycle pulse: return all engines to idle
//  init_start out  1                   one-cycle start pulse, init engine
//  ksa_start  out  1                   one-cycle start pulse, shuffle engine
//  dec_start  out  1                   one-cycle start pulse, decrypt engine
//  mem_sel    out  2                   S-memory owner: 0 none, 1 init, 2 ksa, 3 dec
//  key        out  KEY_WIDTH           current candidate key (held stable during a trial)
//  busy       out  1                   search in progress
//  found      out  1                   valid key found (sticky until reset/new start)
//  exhausted  out  1                   KEY_MAX tried with no match (sticky)
// BEHAVIOUR
//  - Reset: state IDLE; key=KEY_MIN; all pulses 0; mem_sel=0; busy=found=exhausted=0; check index=0.
//  - States: IDLE -> CLEAR -> INIT_GO -> INIT_WAIT -> KSA_GO -> KSA_WAIT -> DEC_GO -> DEC_WAIT -> CHECK
//    -> {FOUND | NEXT_KEY -> CLEAR | FAIL}.
//  - IDLE: start=1 -> CLEAR next cycle; key<=KEY_MIN, found/exhausted cleared, busy<=1.
//  - CLEAR: eng_clear=1 for exactly one cycle; mem_sel=0.
//  - *_GO: matching *_start=1 for exactly one cycle; mem_sel set to owner in *_GO and held through *_WAIT.
//  - *_WAIT: stay until matching *_done=1; done sampled only in own WAIT state; stray dones elsewhere ignored.
//  - mem_sel changes only on GO entry; never two owners; mem_sel=0 in CLEAR/CHECK/NEXT_KEY/FOUND/FAIL/IDLE.
//  - CHECK: one byte per cycle, index 0..MSG_DEP-1; byte valid iff 8'h61..8'h7A or 8'h20.
//    First invalid byte -> NEXT_KEY (early abort); all MSG_DEP valid -> FOUND. Index reset to 0 on CHECK exit.
//  - NEXT_KEY: if key==KEY_MAX -> FAIL, else key<=key+1 -> CLEAR. No wrap past KEY_MAX.
//  - FOUND: found=1, busy=0, key frozen at matching value; FAIL: exhausted=1, busy=0, key=KEY_MAX.
//    Both terminal until reset or start=1 (start re-enters search as from IDLE).
//  - start while busy: ignored.
//  - reset mid-trial: controller to IDLE next edge; eng_clear not issued (engines share reset).
//  - Latency per rejected key: 1+2+2+2 + engine times + check cycles(1..MSG_DEP) + 1.
//  - KEY_MIN==KEY_MAX: single trial, then FOUND or FAIL.
//  - All outputs registered.
// STRUCTURE
//  - rc4_pkg: state enum typedef, MEM_SEL_{NONE,INIT,KSA,DEC} constants, CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SP=8'h20.
//  - Sub-module rc4_plaintext_checker: start/index counter/valid-bad outputs; FSM drives it from CHECK.
//  - Key counter and sequencing FSM stay in this module.
// TESTING
//  1 Reset: hold reset 3 cycles -> busy=0, found=0, exhausted=0, key=0, mem_sel=0, no pulses.
//  2 Handshake order: start, engine models done after 5 cycles -> pulses exactly init,ksa,dec once each, mem_sel 1,2,3.
//  3 Match: decrypted="attack at dawn..." (all a-z/space) on key 24'h000003 -> found=1, key=3, busy=0.
//  4 Early abort: byte0=8'h41 -> NEXT_KEY after 1 CHECK cycle; key increments by 1, eng_clear pulses once.
//  5 Exhaust: KEY_MIN=24'h3FFFFE, KEY_MAX=24'h3FFFFF, always invalid -> exhausted=1 after 2 trials, key=24'h3FFFFF.
//  6 Reset mid-trial in KSA_WAIT and spurious dec_done in INIT_WAIT -> IDLE next edge; dec_done ignored.

Source files
------------

// File: rtl/rc4_pkg.sv
//------------------------------------------------------------------------------
// rc4_pkg : controller states, S-memory owner codes, plaintext character set
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CLEAR     = 4'd1,
        ST_INIT_GO   = 4'd2,
        ST_INIT_WAIT = 4'd3,
        ST_KSA_GO    = 4'd4,
        ST_KSA_WAIT  = 4'd5,
        ST_DEC_GO    = 4'd6,
        ST_DEC_WAIT  = 4'd7,
        ST_CHECK     = 4'd8,
        ST_NEXT_KEY  = 4'd9,
        ST_FOUND     = 4'd10,
        ST_FAIL      = 4'd11
    } state_t;

    localparam logic [1:0] MEM_SEL_NONE = 2'd0;
    localparam logic [1:0] MEM_SEL_INIT = 2'd1;
    localparam logic [1:0] MEM_SEL_KSA  = 2'd2;
    localparam logic [1:0] MEM_SEL_DEC  = 2'd3;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    function automatic logic is_plain_char(input logic [7:0] b);
        return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rc4_plaintext_checker.sv
//------------------------------------------------------------------------------
// rc4_plaintext_checker : walks the decrypted message one byte per cycle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rc4_plaintext_checker
    import rc4_pkg::*;
#(
    parameter int MSG_DEP   = 32,
    parameter int MSG_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              active,
    input  logic [MSG_DEP-1:0][MSG_WIDTH-1:0] decrypted,
    output logic                              byte_bad,
    output logic                              all_valid
);

    localparam int               IDX_W    = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_DEP - 1);

    logic [IDX_W-1:0] r_index;
    logic             w_byte_ok;
    logic             w_last;

    assign w_byte_ok = is_plain_char(8'(decrypted[r_index]));
    assign w_last    = (r_index == LAST_IDX);
    assign byte_bad  = active && !w_byte_ok;
    assign all_valid = active && w_byte_ok && w_last;

    // Index parks at 0 whenever the scan is not continuing, so every CHECK starts at byte 0
    always_ff @(posedge clk) begin
        if (reset || start || !active || !w_byte_ok || w_last) begin
            r_index <= '0;
        end else begin
            r_index <= r_index + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rc4_key_search_ctrl.sv
//------------------------------------------------------------------------------
// rc4_key_search_ctrl : key iterator and phase sequencer for the RC4 breaker
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MIN   = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF,
    parameter int                   MSG_DEP   = 32,
    parameter int                   MSG_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              init_done,
    input  logic                              ksa_done,
    input  logic                              dec_done,
    input  logic [MSG_DEP-1:0][MSG_WIDTH-1:0] decrypted,
    output logic                              eng_clear,
    output logic                              init_start,
    output logic                              ksa_start,
    output logic                              dec_start,
    output logic [1:0]                        mem_sel,
    output logic [KEY_WIDTH-1:0]              key,
    output logic                              busy,
    output logic                              found,
    output logic                              exhausted
);

    state_t r_state;
    logic   w_byte_bad;
    logic   w_all_valid;

    rc4_plaintext_checker #(
        .MSG_DEP   (MSG_DEP),
        .MSG_WIDTH (MSG_WIDTH)
    ) u_checker (
        .clk       (clk),
        .reset     (reset),
        .start     (r_state == ST_DEC_WAIT),
        .active    (r_state == ST_CHECK),
        .decrypted (decrypted),
        .byte_bad  (w_byte_bad),
        .all_valid (w_all_valid)
    );

    // Outputs are assigned on the transition into the state that owns them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            key        <= KEY_MIN;
            eng_clear  <= 1'b0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            mem_sel    <= MEM_SEL_NONE;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
        end else begin
            eng_clear  <= 1'b0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (start) begin
                        r_state   <= ST_CLEAR;
                        key       <= KEY_MIN;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        busy      <= 1'b1;
                        eng_clear <= 1'b1;
                        mem_sel   <= MEM_SEL_NONE;
                    end
                end
                ST_CLEAR: begin
                    r_state    <= ST_INIT_GO;
                    init_start <= 1'b1;
                    mem_sel    <= MEM_SEL_INIT;
                end
                ST_INIT_GO: r_state <= ST_INIT_WAIT;
                ST_INIT_WAIT: begin
                    if (init_done) begin
                        r_state   <= ST_KSA_GO;
                        ksa_start <= 1'b1;
                        mem_sel   <= MEM_SEL_KSA;
                    end
                end
                ST_KSA_GO: r_state <= ST_KSA_WAIT;
                ST_KSA_WAIT: begin
                    if (ksa_done) begin
                        r_state   <= ST_DEC_GO;
                        dec_start <= 1'b1;
                        mem_sel   <= MEM_SEL_DEC;
                    end
                end
                ST_DEC_GO: r_state <= ST_DEC_WAIT;
                ST_DEC_WAIT: begin
                    if (dec_done) begin
                        r_state <= ST_CHECK;
                        mem_sel <= MEM_SEL_NONE;
                    end
                end
                ST_CHECK: begin
                    if (w_byte_bad) begin
                        r_state <= ST_NEXT_KEY;
                    end else if (w_all_valid) begin
                        r_state <= ST_FOUND;
                        found   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ST_NEXT_KEY: begin
                    if (key == KEY_MAX) begin
                        r_state   <= ST_FAIL;
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        r_state   <= ST_CLEAR;
                        key       <= key + 1'b1;
                        eng_clear <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    mem_sel <= MEM_SEL_NONE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
//------------------------------------------------------------------------------
// tb_rc4_key_search_ctrl : engine models, message reference model and checks
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rc4_key_search_ctrl;

    localparam int MSG_DEP = 32;
    localparam int BUDGET  = 1000;

    typedef struct {
        logic [7:0] b;
        int         pos;
        bit         valid;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic init_done, ksa_done, dec_done;
    logic m_init_done = 1'b0, m_ksa_done = 1'b0, m_dec_done = 1'b0, f_dec_done = 1'b0;
    logic [MSG_DEP-1:0][7:0] decrypted = '0;

    logic        eng_clear, init_start, ksa_start, dec_start, busy, found, exhausted;
    logic [1:0]  mem_sel;
    logic [23:0] key;
    logic        x_eng_clear, x_init_start, x_ksa_start, x_dec_start, x_busy, x_found, x_exhausted;
    logic [1:0]  x_mem_sel;
    logic [23:0] x_key;

    assign init_done = m_init_done;
    assign ksa_done  = m_ksa_done;
    assign dec_done  = m_dec_done | f_dec_done;

    int cyc = 0, n_checks = 0, n_err = 0, proto_err = 0;
    int n_init = 0, n_ksa = 0, n_dec = 0;
    int li = 5, lk = 5, ld = 5;
    int ci = -1, ck = -1, cd = -1;
    int last_owner = 0;
    logic [1:0]  prev_sel = 2'd0;
    logic [3:0]  prev_pulses = 4'd0;
    logic [23:0] prev_key = 24'd0;
    logic        prev_reset = 1'b1;
    logic [7:0]  msgs [0:7][0:MSG_DEP-1];
    vec_t        vecs [8];

    rc4_key_search_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .init_done(init_done), .ksa_done(ksa_done), .dec_done(dec_done),
        .decrypted(decrypted),
        .eng_clear(eng_clear), .init_start(init_start), .ksa_start(ksa_start),
        .dec_start(dec_start), .mem_sel(mem_sel), .key(key),
        .busy(busy), .found(found), .exhausted(exhausted)
    );

    rc4_key_search_ctrl #(.KEY_MIN(24'h3FFFFE), .KEY_MAX(24'h3FFFFF)) dut_x (
        .clk(clk), .reset(reset), .start(start),
        .init_done(init_done), .ksa_done(ksa_done), .dec_done(dec_done),
        .decrypted(decrypted),
        .eng_clear(x_eng_clear), .init_start(x_init_start), .ksa_start(x_ksa_start),
        .dec_start(x_dec_start), .mem_sel(x_mem_sel), .key(x_key),
        .busy(x_busy), .found(x_found), .exhausted(x_exhausted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engines: done rises L cycles after the start pulse and holds until cleared
    always @(negedge clk) begin
        if (reset || eng_clear) begin
            m_init_done = 1'b0; m_ksa_done = 1'b0; m_dec_done = 1'b0;
            ci = -1; ck = -1; cd = -1;
        end else begin
            if (init_start) ci = li;
            else if (ci > 0) begin ci = ci - 1; if (ci == 0) m_init_done = 1'b1; end
            if (ksa_start) ck = lk;
            else if (ck > 0) begin ck = ck - 1; if (ck == 0) m_ksa_done = 1'b1; end
            if (dec_start) begin
                cd = ld;
                for (int i = 0; i < MSG_DEP; i++) decrypted[i] = msgs[key[2:0]][i];
            end else if (cd > 0) begin cd = cd - 1; if (cd == 0) m_dec_done = 1'b1; end
        end
    end

    // Handshake rules watched on every cycle of the main instance
    always @(negedge clk) begin
        if (reset) begin
            last_owner = 0; prev_sel = 2'd0; prev_pulses = 4'd0;
        end else begin
            if (init_start) n_init++;
            if (ksa_start)  n_ksa++;
            if (dec_start)  n_dec++;
            if ((int'(eng_clear) + int'(init_start) + int'(ksa_start) + int'(dec_start)) > 1) proto_err++;
            if (({eng_clear, init_start, ksa_start, dec_start} & prev_pulses) != 4'd0) proto_err++;
            if (eng_clear) last_owner = 0;
            if (mem_sel != prev_sel && mem_sel != 2'd0) begin
                if (int'(mem_sel) != last_owner + 1) proto_err++;
                if (!((mem_sel == 2'd1 && init_start) || (mem_sel == 2'd2 && ksa_start) ||
                      (mem_sel == 2'd3 && dec_start))) proto_err++;
                last_owner = int'(mem_sel);
            end
            if ((init_start && mem_sel != 2'd1) || (ksa_start && mem_sel != 2'd2) ||
                (dec_start && mem_sel != 2'd3)) proto_err++;
            if ((eng_clear || found || exhausted || !busy) && mem_sel != 2'd0) proto_err++;
            if (!prev_reset && key != prev_key && !eng_clear) proto_err++;
            prev_sel    = mem_sel;
            prev_pulses = {eng_clear, init_start, ksa_start, dec_start};
        end
        prev_key   = key;
        prev_reset = reset;
    end

    function automatic bit ref_ok(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic int ref_check_cycles(input int k);
        for (int i = 0; i < MSG_DEP; i++) if (!ref_ok(msgs[k][i])) return i + 1;
        return MSG_DEP;
    endfunction

    function automatic bit ref_accepts(input int k);
        for (int i = 0; i < MSG_DEP; i++) if (!ref_ok(msgs[k][i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] rand_ok();
        int r;
        r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        while (ref_ok(b)) b = 8'($urandom_range(0, 255));
        return b;
    endfunction

    task automatic gen_good(input int k);
        for (int i = 0; i < MSG_DEP; i++) msgs[k][i] = rand_ok();
    endtask

    task automatic gen_bad(input int k);
        int p;
        p = $urandom_range(0, MSG_DEP - 1);
        for (int i = 0; i < MSG_DEP; i++)
            msgs[k][i] = (i < p) ? rand_ok() : ((i == p) ? rand_bad() : 8'($urandom_range(0, 255)));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One trial from its eng_clear; outcome 0 rejected, 1 found, 2 exhausted, 3 timeout
    task automatic trial(output int len, output int outcome);
        int c0, t;
        t = 0;
        while (!eng_clear && t < BUDGET) begin @(negedge clk); t++; end
        if (!eng_clear) begin len = 0; outcome = 3; return; end
        c0 = cyc;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!eng_clear && !found && !exhausted && t < BUDGET);
        len = cyc - c0;
        outcome = eng_clear ? 0 : (found ? 1 : (exhausted ? 2 : 3));
    endtask

    // Full search from start; expected key, trial lengths and outcomes come from the message model
    task automatic search(input string tag);
        int len, oc, a_i, a_k, a_d, s, exp_key;
        s = li + lk + ld;
        exp_key = 0;
        while (exp_key < 7 && !ref_accepts(exp_key)) exp_key++;
        pulse_start();
        for (int k = 0; k <= exp_key; k++) begin
            a_i = n_init; a_k = n_ksa; a_d = n_dec;
            trial(len, oc);
            check({tag, " outcome"}, 32'(oc), ref_accepts(k) ? 32'd1 : 32'd0);
            check({tag, " trial_len"}, 32'(len),
                  32'(s + ref_check_cycles(k) + (ref_accepts(k) ? 4 : 5)));
            check({tag, " pulses"}, 32'({8'(n_init - a_i), 8'(n_ksa - a_k), 8'(n_dec - a_d)}), 32'h010101);
            if (oc != 0) break;
        end
        check({tag, " key"}, 32'(key), 32'(exp_key));
        check({tag, " found/busy"}, 32'({found, busy}), 32'b10);
    endtask

    initial begin
        int len, oc, t, a_d;
        string s;

        vecs[0] = '{8'h61, 0, 1'b1};  vecs[1] = '{8'h7A, 5, 1'b1};
        vecs[2] = '{8'h20, 31, 1'b1}; vecs[3] = '{8'h60, 0, 1'b0};
        vecs[4] = '{8'h7B, 3, 1'b0};  vecs[5] = '{8'h1F, 31, 1'b0};
        vecs[6] = '{8'h21, 10, 1'b0}; vecs[7] = '{8'h41, 0, 1'b0};
        for (int k = 0; k < 8; k++) gen_good(k);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy/found/exh", 32'({busy, found, exhausted}), 32'd0);
        check("rst key", 32'(key), 32'd0);
        check("rst mem_sel", 32'(mem_sel), 32'd0);
        check("rst pulses", 32'({eng_clear, init_start, ksa_start, dec_start}), 32'd0);
        check("rst x_key", 32'(x_key), 32'h3FFFFE);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle stays idle", 32'({busy, eng_clear, x_eng_clear, x_init_start}), 32'd0);

        // Character-class boundaries, one search per vector
        li = 2; lk = 3; ld = 1;
        foreach (vecs[v]) begin
            for (int k = 0; k < 8; k++) for (int i = 0; i < MSG_DEP; i++) msgs[k][i] = 8'h61;
            msgs[0][vecs[v].pos] = vecs[v].b;
            do_reset();
            pulse_start();
            trial(len, oc);
            check($sformatf("vec%0d outcome", v), 32'(oc), vecs[v].valid ? 32'd1 : 32'd0);
            check($sformatf("vec%0d trial_len", v), 32'(len),
                  32'(li + lk + ld + (vecs[v].valid ? 4 + MSG_DEP : 6 + vecs[v].pos)));
            check($sformatf("vec%0d key", v), 32'(key), vecs[v].valid ? 32'd0 : 32'd1);
        end

        // Known plaintext on key 3, engines take 5 cycles each
        li = 5; lk = 5; ld = 5;
        s = "attack at dawn and hold the gate";
        for (int k = 0; k < 3; k++) gen_bad(k);
        for (int i = 0; i < MSG_DEP; i++) msgs[3][i] = (i < s.len()) ? s[i] : 8'h20;
        do_reset();
        search("match");
        pulse_start();
        check("restart from found", 32'({found, busy, eng_clear}), 32'b011);
        check("restart key", 32'(key), 32'd0);

        // Randomized searches
        for (int r = 0; r < 4; r++) begin
            int tgt;
            tgt = $urandom_range(0, 5);
            li = $urandom_range(1, 6); lk = $urandom_range(1, 6); ld = $urandom_range(1, 6);
            for (int k = 0; k < 8; k++) if (k < tgt) gen_bad(k); else gen_good(k);
            do_reset();
            search($sformatf("rand%0d", r));
        end

        // Early abort and exhaustion (second instance spans only two keys)
        li = 2; lk = 2; ld = 2;
        for (int k = 0; k < 8; k++) begin gen_good(k); msgs[k][0] = 8'h41; end
        do_reset();
        pulse_start();
        trial(len, oc);
        check("abort outcome", 32'(oc), 32'd0);
        check("abort trial_len", 32'(len), 32'(li + lk + ld + 6));
        check("abort key+1", 32'(key), 32'd1);
        check("x second key", 32'({x_busy, x_key}), 32'h13FFFFF);
        t = 0;
        while (!x_exhausted && t < 200) begin @(negedge clk); t++; end
        check("x exhausted", 32'({x_exhausted, x_found, x_busy}), 32'b100);
        check("x final key", 32'(x_key), 32'h3FFFFF);
        repeat (4) @(negedge clk);
        check("x exhausted sticky", 32'({x_exhausted, x_mem_sel, x_eng_clear, x_ksa_start, x_dec_start}), 32'b100000);

        // Stray dec_done and start while busy in INIT_WAIT, then reset inside KSA_WAIT
        li = 5; lk = 10; ld = 2;
        do_reset();
        pulse_start();
        repeat (2) @(negedge clk);
        a_d = n_dec;
        f_dec_done = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        f_dec_done = 1'b0; start = 1'b0;
        check("stray dec mem_sel", 32'({mem_sel, eng_clear}), 32'b010);
        check("busy start key", 32'(key), 32'd0);
        t = 0;
        while (!ksa_start && t < 50) begin @(negedge clk); t++; end
        check("ksa after init", 32'({ksa_start, mem_sel}), 32'b110);
        check("no dec_start", 32'(n_dec - a_d), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset idle", 32'({busy, mem_sel, eng_clear, init_start, ksa_start, dec_start}), 32'd0);
        check("mid reset keys", 32'(key) + 32'(x_key), 32'h3FFFFE);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post reset quiet", 32'({busy, eng_clear, found, exhausted}), 32'd0);

        check("protocol", 32'(proto_err), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
